// File: rtl/encoder_pkg.sv
// Shared widths, index type and small priority-encode helpers for the
// 32x5 encoder slice.
package encoder_pkg;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 5;

  typedef logic [IDX_W-1:0] idx_t;

  // Lowest set bit wins when lsb=1, highest when lsb=0; 0 when v==0.
  function automatic logic [2:0] pe8(input logic [7:0] v, input logic lsb);
    logic [2:0] r;
    r = '0;
    if (lsb) begin
      for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [1:0] pe4(input logic [3:0] v, input logic lsb);
    logic [1:0] r;
    r = '0;
    if (lsb) begin
      for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    end else begin
      for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    end
    return r;
  endfunction
endpackage

// File: rtl/prio_enc_32x5.sv
// Combinational 32->5 priority encoder: four 8->3 group encoders picked by a
// 4->2 group encoder, so the group index becomes idx[4:3].
module prio_enc_32x5
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [WORD_W-1:0] word,
  output idx_t              idx,
  output logic              valid
);
  logic [3:0][2:0] grp_idx;
  logic [3:0]      grp_vld;
  logic [1:0]      grp_sel;

  for (genvar g = 0; g < 4; g++) begin : g_grp
    assign grp_vld[g] = |word[g*8 +: 8];
    assign grp_idx[g] = pe8(word[g*8 +: 8], LSB_FIRST);
  end

  assign grp_sel = pe4(grp_vld, LSB_FIRST);
  assign idx     = {grp_sel, grp_idx[grp_sel]};
  assign valid   = |grp_vld;
endmodule

// File: rtl/encoder_32x5_drain.sv
// Holds a multi-hot word as a pending mask and drains it one set-bit index
// per output beat, in priority order, flagging the final beat.
module encoder_32x5_drain
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output idx_t              out_idx,
  output logic              out_last,
  output logic              zero_drop,
  output logic              busy
);
  logic [WORD_W-1:0] pend;
  logic              enc_vld;
  logic              in_fire, out_fire;

  prio_enc_32x5 #(.LSB_FIRST(LSB_FIRST)) u_enc (
    .word  (pend),
    .idx   (out_idx),
    .valid (enc_vld)
  );

  assign busy      = enc_vld;
  assign out_valid = busy;
  assign out_last  = busy && ((pend & (pend - WORD_W'(1))) == '0);
  // Last beat frees the slot in the same cycle so words stream without a bubble.
  assign in_ready  = !busy || (out_valid && out_ready && out_last);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      zero_drop <= 1'b0;
    end else begin
      if (in_fire)       pend <= in_word;
      else if (out_fire) pend <= pend & ~(WORD_W'(1) << out_idx);
      zero_drop <= in_fire && (in_word == '0);
    end
  end
endmodule
